// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Contents: FSM state encoding, requester IDs, parameter legal ranges
// and internal counter widths.
package mem_arb_pkg;

   localparam int unsigned MEM_LAT_MIN    = 1;
   localparam int unsigned MEM_LAT_MAX    = 4;
   localparam int unsigned STARVE_MAX_MIN = 1;
   localparam int unsigned STARVE_MAX_MAX = 15;

   // Counters sized for the largest legal parameter values.
   localparam int unsigned LAT_CNT_W    = 3;
   localparam int unsigned STARVE_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01
   } arb_state_e;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_DMA  = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks one outstanding memory read: counts down the fixed read latency,
// remembers which requester owns the read and steers rvalid/rdata to it.
// Ports:
//   clk, rst            clock, async active-high reset
//   start_i, id_i       load the latency counter and latch the owner
//   mem_rdata_i         read data from the memory macro
//   done_o              last cycle of the read (rvalid cycle)
//   core_/dma_rvalid_o  per-requester read-valid pulse
//   core_/dma_rdata_o   per-requester read data, held between reads
module mem_rd_tracker
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  req_id_e           id_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              done_o,
   output logic              core_rvalid_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] core_rdata_o,
   output logic [DATA_W-1:0] dma_rdata_o
);

   logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   req_id_e              id_q, id_d;
   logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0]    dma_rdata_q, dma_rdata_d;

   // Countdown, owner latch and capture of returned data.
   always_comb begin
      lat_cnt_d    = lat_cnt_q;
      id_d         = id_q;
      core_rdata_d = core_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      done_o       = (lat_cnt_q == LAT_CNT_W'(1));
      if (start_i) begin
         lat_cnt_d = LAT_CNT_W'(MEM_LAT);
         id_d      = id_i;
      end else if (lat_cnt_q != '0) begin
         lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
      end
      if (done_o) begin
         if (id_q == REQ_DMA) dma_rdata_d  = mem_rdata_i;
         else                 core_rdata_d = mem_rdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt_q    <= '0;
         id_q         <= REQ_CORE;
         core_rdata_q <= '0;
         dma_rdata_q  <= '0;
      end else begin
         lat_cnt_q    <= lat_cnt_d;
         id_q         <= id_d;
         core_rdata_q <= core_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   // Memory data passes straight through in the valid cycle, then the
   // captured copy holds it; the other requester's data is untouched.
   assign core_rvalid_o = done_o && (id_q == REQ_CORE);
   assign dma_rvalid_o  = done_o && (id_q == REQ_DMA);
   assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : core_rdata_q;
   assign dma_rdata_o   = dma_rvalid_o  ? mem_rdata_i : dma_rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between the core memory
// port and the DMA/loader port. Grants are combinational in IDLE; reads
// block further grants until their data returns.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects alternating priority on
// conflict instead of core priority with a DMA starvation bound.
// Ports:
//   clk, rst                              clock, async active-high reset
//   core_req/we/addr/wdata, core_gnt      core request bundle and grant
//   core_rvalid, core_rdata               core read return
//   dma_req/we/addr/wdata, dma_gnt        DMA request bundle and grant
//   dma_rvalid, dma_rdata                 DMA read return
//   mem_en/we/addr/wdata, mem_rdata       memory macro interface
//   busy                                  a read is outstanding
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // Elaboration-time parameter range checks.
   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT out of range");
   end
   if (STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_MAX out of range");
   end

   arb_state_e state_q, state_d;
   logic       core_pri;
   logic       core_win;
   logic       rd_start;
   req_id_e    rd_id;
   logic       rd_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Last-winner flag; resets to DMA so the core wins the first conflict.
   logic last_dma_q, last_dma_d;

   assign core_pri = last_dma_q;

   always_comb begin
      last_dma_d = last_dma_q;
      if (core_gnt)     last_dma_d = 1'b0;
      else if (dma_gnt) last_dma_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_dma_q <= 1'b1;
      else     last_dma_q <= last_dma_d;
   end
`else
   // Consecutive core grants while DMA waits; DMA wins once it saturates.
   logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign core_pri = (starve_cnt_q != STARVE_CNT_W'(STARVE_MAX));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!dma_req || dma_gnt) begin
         starve_cnt_d = '0;
      end else if (core_gnt && (starve_cnt_q != STARVE_CNT_W'(STARVE_MAX))) begin
         starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_cnt_q <= '0;
      else     starve_cnt_q <= starve_cnt_d;
   end
`endif

   assign core_win = core_req && (!dma_req || core_pri);

   // Next-state and combinational grant / memory drive.
   always_comb begin
      state_d   = state_q;
      core_gnt  = 1'b0;
      dma_gnt   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rd_start  = 1'b0;
      rd_id     = REQ_CORE;
      case (state_q)
         IDLE: begin
            if (core_win) begin
               core_gnt  = 1'b1;
               mem_en    = 1'b1;
               mem_we    = core_we;
               mem_addr  = core_addr;
               mem_wdata = core_wdata;
               rd_start  = !core_we;
               rd_id     = REQ_CORE;
            end else if (dma_req) begin
               dma_gnt   = 1'b1;
               mem_en    = 1'b1;
               mem_we    = dma_we;
               mem_addr  = dma_addr;
               mem_wdata = dma_wdata;
               rd_start  = !dma_we;
               rd_id     = REQ_DMA;
            end
            if (rd_start) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (rd_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign busy = (state_q == RD_WAIT);

   mem_rd_tracker #(
      .DATA_W  (DATA_W),
      .MEM_LAT (MEM_LAT)
   ) u_rd_tracker (
      .clk           (clk),
      .rst           (rst),
      .start_i       (rd_start),
      .id_i          (rd_id),
      .mem_rdata_i   (mem_rdata),
      .done_o        (rd_done),
      .core_rvalid_o (core_rvalid),
      .dma_rvalid_o  (dma_rvalid),
      .core_rdata_o  (core_rdata),
      .dma_rdata_o   (dma_rdata)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// memory and a read-return scoreboard.
module tb_mem_port_arbiter;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned LAT    = 2;
   localparam int unsigned SMAX   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          core_req = 1'b0, core_we = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic          core_gnt, core_rvalid, dma_gnt, dma_rvalid;
   logic [DW-1:0] core_rdata, dma_rdata;
   logic          mem_en, mem_we, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit            is_dma;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   // Model state for arbitration expectations.
   int m_starve   = 0;
   bit m_last_dma = 1'b1;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt),
      .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Behavioural memory: writes land at the clock edge, read data appears
   // LAT cycles after the access cycle.
   logic [DW-1:0] mem_arr [64];
   logic [DW-1:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
      rd_pipe[0] <= mem_arr[mem_addr[7:2]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-return scoreboard.
   always @(negedge clk) begin
      if (core_rvalid || dma_rvalid) begin
         chk("rvalid_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rv_port", {dma_rvalid, core_rvalid}, e.is_dma ? 2'b10 : 2'b01);
            chk("rv_data", e.is_dma ? dma_rdata : core_rdata, e.data);
         end
      end
   end

   // Single-requester access from IDLE; reads also check return latency.
   task automatic access(input bit is_dma, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
      int n;
      if (is_dma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = data;
      end else begin
         core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = data;
      end
      @(negedge clk);
      chk("acc_gnt", {dma_gnt, core_gnt}, is_dma ? 2'b10 : 2'b01);
      chk("acc_mem", {mem_en, mem_we, mem_addr}, {1'b1, we, addr});
      if (!we) sb.push_back('{is_dma, data});
      tick();
      core_req = 1'b0;
      dma_req  = 1'b0;
      if (!we) begin
         n = 0;
         while (!(core_rvalid || dma_rvalid) && n < 8) begin
            tick();
            n++;
         end
         chk("acc_rd_lat", 64'(n), 64'(LAT - 1));
         tick();
      end
   endtask

   // Continuous write conflicts checked against the arbitration model.
   task automatic run_writes(input int n, input bit dreq);
      bit exp_dma;
      for (int i = 0; i < n; i++) begin
         core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = 32'(i);
         dma_req  = dreq; dma_we  = 1'b1; dma_addr  = 32'h34; dma_wdata  = 32'(i + 100);
         @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_dma = dreq && !m_last_dma;
`else
         exp_dma = dreq && (m_starve == SMAX);
`endif
         chk("arb_gnt", {dma_gnt, core_gnt}, exp_dma ? 2'b10 : 2'b01);
         chk("arb_mem", {mem_en, mem_we, mem_addr}, {2'b11, exp_dma ? 32'h34 : 32'h30});
         m_last_dma = exp_dma;
         if (!dreq || exp_dma)  m_starve = 0;
         else if (m_starve < SMAX) m_starve++;
         tick();
      end
      core_req = 1'b0;
      dma_req  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_ctrl", {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, busy}, 7'd0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rdata", {core_rdata, dma_rdata}, 0);
      tick();
      rst = 1'b0;
      tick();

      // Back-to-back writes under conflict: core then DMA
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'd5;
      dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h24; dma_wdata  = 32'd7;
      @(negedge clk);
      chk("b2b_gnt0", {dma_gnt, core_gnt}, 2'b01);
      chk("b2b_mem0", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h20, 32'd5});
      tick();
      core_req = 1'b0;
      @(negedge clk);
      chk("b2b_gnt1", {dma_gnt, core_gnt}, 2'b10);
      chk("b2b_mem1", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h24, 32'd7});
      chk("b2b_busy", busy, 0);
      tick();
      dma_req = 1'b0;

      // Preload via DMA, then core-only read with per-cycle busy/rvalid
      access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      @(negedge clk);
      chk("rd_gnt", {dma_gnt, core_gnt, mem_en, mem_we}, 4'b0110);
      chk("rd_addr", mem_addr, 32'h10);
      chk("rd_busy0", busy, 0);
      sb.push_back('{1'b0, 32'hDEADBEEF});
      tick();
      core_req = 1'b0;
      @(negedge clk);
      chk("rd_c1", {busy, core_rvalid, core_gnt}, 3'b100);
      tick();
      @(negedge clk);
      chk("rd_c2", {busy, core_rvalid}, 2'b11);
      chk("rd_c2_data", core_rdata, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("rd_c3", {busy, core_rvalid}, 2'b00);
      chk("rd_hold", {core_rdata, dma_rdata}, {32'hDEADBEEF, 32'h0});
      tick();

      // Read back the earlier writes; DMA is the last winner afterwards
      access(1'b0, 1'b0, 32'h20, 32'd5);
      access(1'b1, 1'b0, 32'h24, 32'd7);
      chk("rdata_hold_both", {core_rdata, dma_rdata}, {32'd5, 32'd7});

      // Starvation bound / alternation, including counter clear on dma_req=0
      m_starve   = 0;
      m_last_dma = 1'b1;
      run_writes(10, 1'b1);
      run_writes(3, 1'b1);
      run_writes(1, 1'b0);
      run_writes(5, 1'b1);
      tick();

      // DMA request during core read waits until after rvalid
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
      @(negedge clk);
      chk("blk_gnt0", {dma_gnt, core_gnt}, 2'b01);
      sb.push_back('{1'b0, 32'd5});
      tick();
      core_req = 1'b0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h28; dma_wdata = 32'd9;
      @(negedge clk);
      chk("blk_c1", {dma_gnt, core_gnt, busy}, 3'b001);
      tick();
      @(negedge clk);
      chk("blk_c2", {dma_gnt, core_rvalid}, 2'b01);
      tick();
      @(negedge clk);
      chk("blk_c3", {dma_gnt, busy, mem_we, mem_addr}, {3'b101, 32'h28});
      tick();
      dma_req = 1'b0;
      access(1'b0, 1'b0, 32'h28, 32'd9);

      // Reset one cycle after a read grant drops that read
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      @(negedge clk);
      chk("rr_gnt", core_gnt, 1);
      tick();
      core_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rr_ctrl", {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_en, mem_we, busy}, 7'd0);
      chk("rr_addr", mem_addr, 0);
      chk("rr_rdata", {core_rdata, dma_rdata}, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_quiet", {core_rvalid, dma_rvalid, busy}, 3'b000);
         tick();
      end
      access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);

      repeat (3) tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory between two requesters: the multicycle core controller's memory port and a DMA/loader port used for program load and debug. Memory reads have a fixed latency. Sits between the core datapath's address mux and the memory macro. Applies core-priority arbitration with a starvation bound for DMA.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles, legal 1..4
STARVE_MAX, 4, maximum consecutive core grants while DMA request is pending, legal 1..15

Ports:
clk  in  1  clock
rst  in  1  reset
core_req  in  1  core access request; held until core_gnt
core_we  in  1  core write enable
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  one-cycle grant pulse to core
core_rvalid  out  1  one-cycle core read data valid
core_rdata  out  DATA_W  core read data
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request bundle; same rules as core
dma_gnt  out  1  DMA grant pulse
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en with mem_we=0
busy  out  1  high while a read is outstanding

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: state IDLE; all gnt, rvalid, mem_en, mem_we and busy at 0; all data/address outputs at 0; starvation counter 0; latency counter 0.
- States:
  - IDLE: arbitration occurs here.
  - RD_WAIT: a read is outstanding.
- Grant is combinational in IDLE:
  - The winner's gnt, mem_en, mem_we, mem_addr and mem_wdata are driven in the same cycle.
  - Exactly one gnt may be high per cycle.
  - No grant when no req is high.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting: core wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - starve_cnt increments on each core grant while dma_req=1.
  - starve_cnt clears on a DMA grant, or on any cycle with dma_req=0.
  - starve_cnt saturates at STARVE_MAX.
- Write grant: completes in the grant cycle, with no rvalid. The FSM stays in IDLE, so back-to-back grants are allowed on the next cycle.
- Read grant:
  - The winner's ID is latched, lat_cnt loads MEM_LAT, and the FSM goes to RD_WAIT. busy=1 from the next cycle.
  - In RD_WAIT, lat_cnt decrements each cycle and no grant is issued; requests are held.
  - When lat_cnt reaches 1, the latched requester's rvalid=1 and rdata=mem_rdata for that one cycle, and the FSM returns to IDLE.
  - rvalid therefore occurs exactly MEM_LAT cycles after the grant cycle.
  - The earliest next grant is the cycle after rvalid.
- rdata outputs are registered from mem_rdata in the rvalid cycle and hold their last value otherwise. The non-selected requester's rdata is unchanged.
- A requester dropping req before gnt is legal: no access results.
- Changing address or data while req=1 without gnt is a protocol violation. The arbiter does not check for it.
- Reset mid-read: the pending rvalid is dropped, the FSM returns to IDLE, and no spurious rvalid occurs after reset release.
- An illegal state encoding returns to IDLE.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: on conflict, the arbiter alternates using a last-winner flag (reset value: DMA last, so core wins the first conflict). STARVE_MAX and starve_cnt are unused.
- Undefined: core priority with the starvation bound, as above.
- Port list is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE, RD_WAIT)
  - requester ID constants (REQ_CORE=0, REQ_DMA=1)
  - MEM_LAT and STARVE_MAX legal-range constants
- Sub-module mem_rd_tracker holds the latency counter, latched requester ID, and rvalid/rdata steering. The arbiter FSM and priority logic stay in the top module.

Test Plan:
- Core-only read: MEM_LAT=2, core_req=1 with addr 0x10, mem returns 0xDEADBEEF → core_gnt in cycle 0, core_rvalid=1 with rdata 0xDEADBEEF in cycle 2, busy high in cycles 1–2.
- Back-to-back writes: core write 0x20=5 and DMA write 0x24=7 both requested → core_gnt in cycle 0, dma_gnt in cycle 1; mem_we high in both cycles; no rvalid.
- Starvation bound: STARVE_MAX=4, both requesting writes continuously → 4 core grants, then 1 DMA grant, then core again; pattern repeats.
- Read blocking: DMA requests during a core read's RD_WAIT → no dma_gnt until the cycle after core_rvalid.
- Reset mid-read: assert rst one cycle after a read grant with MEM_LAT=3 → no rvalid ever for that read; outputs 0; next request is granted normally.
- Round-robin build (MEM_ARB_ROUND_ROBIN_EN): both requesting writes continuously → grants alternate core, DMA, core, DMA starting with core.
